// File: rtl/latch_wr_arbiter_pkg.sv
// rtl/latch_wr_arbiter_pkg.sv - shared state encoding and parameter defaults for the latch write arbiter
package latch_wr_arbiter_pkg;

  localparam int DW_DEF     = 8;  // data width of each latch entry
  localparam int AW_DEF     = 2;  // entry address width (NENT = 2**AW)
  localparam int EN_CYC_DEF = 1;  // latch enable high time in cycles (1..15)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ENABLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage

// File: rtl/latch_wr_arbiter_rr_arb2.sv
// rtl/latch_wr_arbiter_rr_arb2.sv - two-way combinational round-robin selector
//
// Ports:
//   req    [1:0] in  : request per requester
//   last         in  : index of the requester granted most recently
//   winner [1:0] out : one-hot winner, zero when no request
module rr_arb2
  import latch_wr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] winner
);

  // A lone request wins outright; on contention the requester that was
  // not served last time goes first.
  always_comb begin
    winner = req;
    if (req == 2'b11) begin
      winner = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/latch_wr_arbiter.sv
// rtl/latch_wr_arbiter.sv - two-requester arbiter driving a bank of level-sensitive latches
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req    [1:0]      : write request per requester, held until its gnt bit
//   addr0/addr1 [AW]  : target entry of requester 0/1
//   data0/data1 [DW]  : write data of requester 0/1
//   gnt    [1:0]      : one-cycle grant pulse (SETUP)
//   done   [1:0]      : one-cycle write-complete pulse (HOLD)
//   lat_d  [DW]       : shared latch data bus
//   lat_en [NENT]     : per-entry latch enable, one-hot or zero
//   busy              : high whenever a write is in progress
module latch_wr_arbiter
  import latch_wr_arbiter_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF,
  parameter int EN_CYC = EN_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [DW-1:0]        data0,
  input  logic [DW-1:0]        data1,
  output logic [1:0]           gnt,
  output logic [1:0]           done,
  output logic [DW-1:0]        lat_d,
  output logic [(2**AW)-1:0]   lat_en,
  output logic                 busy
);

  localparam logic [3:0] EN_LAST = 4'(EN_CYC - 1);

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic          last;     // requester granted most recently
  logic          win;      // requester owning the current write
  logic [AW-1:0] wr_addr;
  logic [1:0]    win_oh;
  logic          take;

  rr_arb2 u_rr_arb2 (
    .req    (req),
    .last   (last),
    .winner (win_oh)
  );

  // Requests are only looked at in IDLE and HOLD; sampling in HOLD is what
  // lets a queued write start with no idle bubble.
  assign take = ((state == ST_IDLE) || (state == ST_HOLD)) && (req != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;          // so requester 0 wins the first contention
      win     <= 1'b0;
      wr_addr <= '0;
      lat_d   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == ST_ENABLE) ? cnt + 4'd1 : 4'd0;
      // addr/data are captured only here, so lat_d is frozen from SETUP
      // through HOLD no matter what the requesters do meanwhile.
      if (take) begin
        win     <= win_oh[1];
        last    <= win_oh[1];
        wr_addr <= win_oh[1] ? addr1 : addr0;
        lat_d   <= win_oh[1] ? data1 : data0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    done      = 2'b00;
    lat_en    = '0;
    busy      = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (take) state_nxt = ST_SETUP;
      end
      ST_SETUP: begin
        gnt[win]  = 1'b1;
        state_nxt = ST_ENABLE;
      end
      ST_ENABLE: begin
        lat_en[wr_addr] = 1'b1;
        if (cnt == EN_LAST) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        done[win] = 1'b1;
        state_nxt = take ? ST_SETUP : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_latch_wr_arbiter.sv
// tb/tb_latch_wr_arbiter.sv - scoreboard bench for latch_wr_arbiter (EN_CYC=1 and EN_CYC=3 instances)
module tb_latch_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // instance with EN_CYC = 1
  logic       rst_n1;
  logic [1:0] req1, a0_1, a1_1, gnt1, done1;
  logic [7:0] d0_1, d1_1, lat_d1;
  logic [3:0] lat_en1;
  logic       busy1;

  // instance with EN_CYC = 3
  logic       rst_n3;
  logic [1:0] req3, a0_3, a1_3, gnt3, done3;
  logic [7:0] d0_3, d1_3, lat_d3;
  logic [3:0] lat_en3;
  logic       busy3;

  latch_wr_arbiter #(.DW(8), .AW(2), .EN_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n1), .req(req1), .addr0(a0_1), .addr1(a1_1),
    .data0(d0_1), .data1(d1_1), .gnt(gnt1), .done(done1), .lat_d(lat_d1),
    .lat_en(lat_en1), .busy(busy1)
  );

  latch_wr_arbiter #(.DW(8), .AW(2), .EN_CYC(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .req(req3), .addr0(a0_3), .addr1(a1_3),
    .data0(d0_3), .data1(d1_3), .gnt(gnt3), .done(done3), .lat_d(lat_d3),
    .lat_en(lat_en3), .busy(busy3)
  );

  // event = {gnt, done, lat_en, lat_d} for any cycle with activity
  typedef logic [15:0] evt_t;
  evt_t q1[$];
  evt_t q3[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic evt_t ev(input logic [1:0] g, input logic [1:0] dn,
                              input logic [3:0] en, input logic [7:0] d);
    return {g, dn, en, d};
  endfunction

  // Expected cycle trace of one complete write: gnt, EN_CYC enables, done.
  task automatic push_wr(input int id, input int who, input logic [1:0] a, input logic [7:0] d);
    logic [1:0] oh;
    logic [3:0] en;
    int         ne;
    oh = (who == 1) ? 2'b10 : 2'b01;
    en = 4'b0001 << a;
    ne = (id == 1) ? 1 : 3;
    if (id == 1) begin
      q1.push_back(ev(oh, 2'b00, 4'b0000, d));
      for (int i = 0; i < ne; i++) q1.push_back(ev(2'b00, 2'b00, en, d));
      q1.push_back(ev(2'b00, oh, 4'b0000, d));
    end else begin
      q3.push_back(ev(oh, 2'b00, 4'b0000, d));
      for (int i = 0; i < ne; i++) q3.push_back(ev(2'b00, 2'b00, en, d));
      q3.push_back(ev(2'b00, oh, 4'b0000, d));
    end
  endtask

  always @(negedge clk) begin
    if (gnt1 != 2'b00 || done1 != 2'b00 || lat_en1 != 4'b0000) begin
      chk("dut1_en_onehot", ($countones(lat_en1) <= 1), 1);
      if (q1.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dut1_unexpected_event: got %0h expected none", {gnt1, done1, lat_en1, lat_d1});
      end else begin
        chk("dut1_event", {gnt1, done1, lat_en1, lat_d1}, q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (gnt3 != 2'b00 || done3 != 2'b00 || lat_en3 != 4'b0000) begin
      chk("dut3_en_onehot", ($countones(lat_en3) <= 1), 1);
      if (q3.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL dut3_unexpected_event: got %0h expected none", {gnt3, done3, lat_en3, lat_d3});
      end else begin
        chk("dut3_event", {gnt3, done3, lat_en3, lat_d3}, q3.pop_front());
      end
    end
  end

  task automatic wait_idle1();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!busy1) break;
    end
    chk("dut1_back_to_idle", busy1, 0);
  endtask

  initial begin
    int busy_cnt;
    int lat;
    int nd;
    int en_cnt;
    int seen;

    rst_n1 = 1'b0; req1 = 2'b11; a0_1 = '0; a1_1 = '0; d0_1 = '0; d1_1 = '0;
    rst_n3 = 1'b0; req3 = 2'b11; a0_3 = '0; a1_3 = '0; d0_3 = '0; d1_3 = '0;

    // reset held with both requests active
    repeat (3) @(negedge clk);
    chk("rst_gnt", gnt1, 0);
    chk("rst_done", done1, 0);
    chk("rst_lat_en", lat_en1, 0);
    chk("rst_lat_d", lat_d1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_busy3", busy3, 0);
    req3 = 2'b00;

    // contention right after reset: 0 first, then 1 with no idle gap
    a0_1 = 2'd0; d0_1 = 8'h11; a1_1 = 2'd3; d1_1 = 8'h22;
    push_wr(1, 0, 2'd0, 8'h11);
    push_wr(1, 1, 2'd3, 8'h22);
    rst_n1 = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt1[0]) req1[0] = 1'b0;
      if (gnt1[1]) req1[1] = 1'b0;
      if (busy1) busy_cnt++;
      else if (busy_cnt > 0) break;
    end
    chk("contention_cycles", busy_cnt, 6);

    // single write, latency to grant
    req1 = 2'b01; a0_1 = 2'd2; d0_1 = 8'hA5;
    push_wr(1, 0, 2'd2, 8'hA5);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (gnt1[0]) break;
    end
    req1 = 2'b00;
    chk("single_gnt_latency", lat, 1);
    wait_idle1();

    // sustained load from fresh reset: 0,1,0,1
    rst_n1 = 1'b0;
    req1 = 2'b11; a0_1 = 2'd1; d0_1 = 8'h33; a1_1 = 2'd2; d1_1 = 8'h44;
    push_wr(1, 0, 2'd1, 8'h33);
    push_wr(1, 1, 2'd2, 8'h44);
    push_wr(1, 0, 2'd1, 8'h33);
    push_wr(1, 1, 2'd2, 8'h44);
    @(negedge clk);
    rst_n1 = 1'b1;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1 != 2'b00) nd++;
      if (nd == 4) begin
        req1 = 2'b00;
        break;
      end
    end
    chk("sustained_done_count", nd, 4);
    wait_idle1();

    // EN_CYC=3, requester 1 alone; data changes mid-ENABLE are ignored
    req3 = 2'b10; a1_3 = 2'd3; d1_3 = 8'h3C;
    push_wr(3, 1, 2'd3, 8'h3C);
    rst_n3 = 1'b1;
    en_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt3[1]) req3 = 2'b00;
      if (lat_en3 != 4'b0000) begin
        en_cnt++;
        d1_3 = 8'hFF;
      end
      if (done3 != 2'b00) break;
    end
    chk("en3_cycles", en_cnt, 3);
    @(negedge clk);
    chk("en3_idle_after", busy3, 0);

    // reset during the second ENABLE cycle aborts the write
    req3 = 2'b01; a0_3 = 2'd1; d0_3 = 8'h77;
    q3.push_back(ev(2'b01, 2'b00, 4'b0000, 8'h77));
    q3.push_back(ev(2'b00, 2'b00, 4'b0010, 8'h77));
    q3.push_back(ev(2'b00, 2'b00, 4'b0010, 8'h77));
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt3[0]) begin
        seen = 1;
        break;
      end
    end
    req3 = 2'b00;
    chk("abort_gnt_seen", seen, 1);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n3 = 1'b0;
    #1;
    chk("abort_lat_en", lat_en3, 0);
    chk("abort_busy", busy3, 0);
    chk("abort_done", done3, 0);
    chk("abort_lat_d", lat_d3, 0);
    repeat (3) @(negedge clk);
    rst_n3 = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_idle", busy3, 0);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/latch_wr_arbiter.md
LATCH_WR_ARBITER -- requirements
Module: latch_wr_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8: data width of each latch entry.
REQ-002 SHALL have parameter AW, default 2: entry address width; number of entries NENT = 2**AW.
REQ-003 SHALL have parameter EN_CYC, default 1, legal range 1..15: number of cycles the latch enable is held high.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, 2: write request, one bit per requester; held high until the matching gnt bit is seen.
REQ-007 SHALL have ports addr0/addr1, input, AW each: target entry of requester 0/1.
REQ-008 SHALL have ports data0/data1, input, DW each: write data of requester 0/1.
REQ-009 SHALL have port gnt, output, 2: one-cycle grant pulse, at most one bit set.
REQ-010 SHALL have port done, output, 2: one-cycle write-complete pulse, at most one bit set.
REQ-011 SHALL have port lat_d, output, DW: shared data bus to all latch entries.
REQ-012 SHALL have port lat_en, output, NENT: per-entry enable, one-hot or zero.
REQ-013 SHALL have port busy, output, 1: high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SETUP, ENABLE, HOLD.
REQ-015 SHALL sample req in IDLE and in HOLD; if any bit is set, it SHALL latch the winner's addr/data and go to SETUP; otherwise it SHALL go to (or stay in) IDLE.
REQ-016 SHALL, in SETUP (exactly 1 cycle), drive lat_d = latched data, lat_en = 0, and gnt[winner] = 1.
REQ-017 SHALL, in ENABLE (exactly EN_CYC cycles, counted by a 4-bit counter), drive lat_en[latched addr] = 1 with lat_d unchanged.
REQ-018 SHALL, in HOLD (exactly 1 cycle), drive lat_en = 0, keep lat_d unchanged, and set done[winner] = 1.
REQ-019 SHALL change lat_d only on entry to SETUP; lat_d is stable one cycle before the enable rises and one cycle after it falls.
REQ-020 Latency SHALL be: req sampled at edge k → gnt in cycle k+1, lat_en in cycles k+2..k+1+EN_CYC, done in cycle k+2+EN_CYC.
REQ-021 Back-to-back writes SHALL be supported: a request sampled at the HOLD exit edge enters SETUP with no IDLE bubble; the per-write period is EN_CYC+2 cycles.
REQ-022 Arbitration SHALL be round-robin: a single request is granted directly; when both requesters are active, the one not granted last wins; the last-granted pointer updates on each grant.
REQ-023 The requester granted in SETUP SHALL drop req by the HOLD exit edge unless it is issuing a new write; req held through HOLD is treated as a new request.
REQ-024 addr/data SHALL be ignored outside the sampling edges; changes during SETUP, ENABLE or HOLD have no effect.

Reset
REQ-025 While rst_n = 0, state SHALL be IDLE, and gnt, done, lat_en, busy SHALL all be 0, lat_d SHALL be 0, the counter SHALL be 0, and the pointer SHALL favour requester 0; all of this is asynchronous.
REQ-026 Reset mid-write SHALL abort the write: lat_en drops immediately and no done is issued for the aborted write.

Structure
REQ-027 A shared package SHALL hold the state enum and the default values of DW, AW and EN_CYC.
REQ-028 Round-robin selection SHALL be a sub-module rr_arb2 (inputs req[1:0], last; output one-hot winner), purely combinational.

Verification
REQ-029 Reset: hold rst_n = 0 with req = 2'b11 → gnt, done, lat_en, lat_d and busy all 0; release → first grant goes to requester 0.
REQ-030 Single write: req = 2'b01, addr0 = 2, data0 = 8'hA5 → gnt = 01 for 1 cycle; lat_en = 4'b0100 for 1 cycle; done = 01; lat_d = A5 from SETUP through HOLD.
REQ-031 Contention: req = 2'b11 from IDLE after reset → requester 0 is served, then requester 1 immediately after HOLD with no IDLE cycle; total 6 cycles.
REQ-032 Sustained load: both requesters continuously high → grant order 0,1,0,1; lat_en never overlaps between writes.
REQ-033 Reset in ENABLE with EN_CYC = 3: assert rst_n = 0 in the 2nd ENABLE cycle → lat_en = 0 asynchronously, no done pulse, busy = 0.
REQ-034 EN_CYC = 3, addr1 = 3, data1 = 8'h3C → lat_en = 4'b1000 for exactly 3 cycles; data1 changed to 8'hFF mid-ENABLE → lat_d stays 3C.
